data_mem_responder: RTL and testbench
=====================================

Name: data_mem_responder

Overview:
- Memory-side responder for the core's load/store path.
- Accepts a single-word request carrying an address, write data, a write-enable and a 4-bit byte strobe (lane 0 = bits 7:0). Performs the byte-masked write or the full-word read after a programmable number of wait states.
- Returns the full read word plus an error flag over a valid/ready response channel. Sign/zero extension stays on the core side.
- Single outstanding transaction; sits between the load/store path and the data-memory array.

Parameters:
- XLEN, 32, data and address width; must be 32 so that there are 4 byte lanes.
- DEPTH_WORDS, 1024, number of XLEN-bit words in the array; power of two.
- WAIT_STATES, 1, extra cycles between acceptance and array access; legal range 0..7.

Ports:
- clk_i  input  1  clock, all state on rising edge
- rst_i  input  1  synchronous reset, active-high
- req_valid_i  input  1  request present
- req_ready_o  output  1  responder can accept a request
- req_we_i  input  1  1 = store, 0 = load
- req_addr_i  input  XLEN  byte address; word index = req_addr_i[log2(DEPTH_WORDS)+1:2]
- req_wdata_i  input  XLEN  store data, lane-aligned
- req_strobe_i  input  4  byte-lane write enables, used only when req_we_i=1
- rsp_valid_o  output  1  response present
- rsp_ready_i  input  1  requester takes the response
- rsp_rdata_o  output  XLEN  read word; 0 for stores and errors
- rsp_err_o  output  1  address out of range

Behaviour:
- Reset: state goes to IDLE, wait counter clears, and outputs are req_ready_o=1, rsp_valid_o=0, rsp_rdata_o=0, rsp_err_o=0. Array contents are not reset.
- FSM states: IDLE, WAIT, RESP.
- IDLE:
  - req_ready_o=1.
  - A handshake (req_valid_i & req_ready_o) latches we, addr, wdata and strobe into internal registers.
  - Next state is WAIT if WAIT_STATES>0; otherwise the access happens at this edge and the next state is RESP.
- WAIT:
  - req_ready_o=0. The counter increments each cycle.
  - When the counter reaches WAIT_STATES-1, the access happens at that edge and the next state is RESP.
- RESP:
  - rsp_valid_o=1. rsp_rdata_o and rsp_err_o stay stable until rsp_ready_i=1.
  - On that handshake edge, return to IDLE.
- Response latency: rsp_valid_o rises exactly WAIT_STATES+1 cycles after the request-handshake edge.
- Throughput: at most one transaction per WAIT_STATES+2 cycles, because req_ready_o is low while in RESP. There is no same-cycle back-to-back accept.
- Access rules:
  - The address is in range if req_addr_i[XLEN-1:log2(DEPTH_WORDS)+2]==0. req_addr_i[1:0] is ignored, since lanes are selected by strobe only.
  - Store, in range: for each lane i with strobe[i]=1, mem[word][8i+7:8i] <= wdata[8i+7:8i]. Other lanes are unchanged. The response has rdata=0 and err=0.
  - Store with strobe 4'b0000: no array change; a normal response is still returned.
  - Load, in range: rdata = mem[word] as sampled at the access edge. A store that is already complete is visible to the next load.
  - Out of range, load or store: no array change; rdata=0, err=1.
- Request inputs are ignored while not in IDLE; req_valid_i is sampled only when req_ready_o=1.
- rsp_ready_i asserted outside RESP has no effect.
- Reset mid-transaction: a store reset in WAIT is dropped and the array is untouched. A response reset in RESP is discarded. Either way the next cycle is IDLE.

Test Plan:
- Reset, WAIT_STATES=1: after rst_i, req_ready_o=1 and rsp_valid_o=0. Store addr 0x10, wdata 0xDEADBEEF, strobe 1111 -> rsp_valid_o 2 cycles after accept with err=0. Load addr 0x10 -> rdata 0xDEADBEEF.
- Byte/half strobes: preload 0x11223344 at 0x20. Store wdata 0x000000AA with strobe 0001 -> load gives 0x112233AA. Store wdata 0x0000BBCC with strobe 0011 -> load gives 0x1122BBCC.
- Backpressure: load with rsp_ready_i held 0 for 5 cycles -> rsp_valid_o and rdata stable throughout and req_ready_o=0. A new req_valid_i in that window is ignored; it is accepted only after the response handshake.
- Out of range, DEPTH_WORDS=1024: store to 0x1000 with strobe 1111 -> err=1, rdata=0. A load of the aliased address 0x0 returns the unchanged prior value.
- Latency sweep, WAIT_STATES=0 and 7: response 1 and 8 cycles after accept respectively. Strobe 0000 store -> normal response, memory unchanged.
- Reset mid-op, WAIT_STATES=3: assert rst_i one cycle after a store to 0x30 is accepted -> no response. A later load of 0x30 returns the old value, and req_ready_o=1 the cycle after reset.

Source files
------------

// File: rtl/data_mem_responder.sv
// data_mem_responder
//   Memory-side responder for the core's load/store path. Accepts one request
//   at a time, waits WAIT_STATES cycles, then performs a byte-masked store or a
//   full-word load on the internal array and presents the result on a
//   valid/ready response channel until the requester takes it.
//
// Ports
//   clk_i, rst_i      clock and synchronous active-high reset
//   req_valid_i/_ready_o  request handshake
//   req_we_i          1 = store, 0 = load
//   req_addr_i        byte address (word index in [log2(DEPTH_WORDS)+1:2])
//   req_wdata_i       lane-aligned store data
//   req_strobe_i      byte-lane write enables (lane 0 = bits 7:0)
//   rsp_valid_o/_ready_i  response handshake
//   rsp_rdata_o       read word; zero for stores and errors
//   rsp_err_o         address out of range
module data_mem_responder #(
  parameter int unsigned XLEN        = 32,
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter int unsigned WAIT_STATES = 1
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            req_valid_i,
  output logic            req_ready_o,
  input  logic            req_we_i,
  input  logic [XLEN-1:0] req_addr_i,
  input  logic [XLEN-1:0] req_wdata_i,
  input  logic [3:0]      req_strobe_i,
  output logic            rsp_valid_o,
  input  logic            rsp_ready_i,
  output logic [XLEN-1:0] rsp_rdata_o,
  output logic            rsp_err_o
);

  localparam int unsigned AW     = $clog2(DEPTH_WORDS);
  localparam int unsigned NLANES = XLEN / 8;
  // Counter value at which the access fires; unused when WAIT_STATES is 0.
  localparam logic [2:0]  LAST_CNT = (WAIT_STATES > 0) ? 3'(WAIT_STATES - 1) : 3'd0;

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_RESP
  } state_e;

  state_e            state_q;
  logic [2:0]        cnt_q;
  logic              we_q;
  logic [XLEN-1:0]   addr_q;
  logic [XLEN-1:0]   wdata_q;
  logic [3:0]        strobe_q;
  logic              req_ready_q;
  logic              rsp_valid_q;
  logic [XLEN-1:0]   rsp_rdata_q;
  logic              rsp_err_q;

  logic [XLEN-1:0]   mem_q [DEPTH_WORDS];

  // Access operands: with zero wait states the access happens on the accept
  // edge, so the operands come straight from the request port; otherwise
  // they come from the registers latched at acceptance.
  logic              acc_fire;
  logic              acc_we;
  logic [XLEN-1:0]   acc_addr;
  logic [XLEN-1:0]   acc_wdata;
  logic [3:0]        acc_strobe;
  logic [AW-1:0]     acc_idx;
  logic              acc_in_range;
  logic [XLEN-1:0]   rsp_rdata_d;
  logic              rsp_err_d;
  logic              unused_addr_lsb;

  always_comb begin
    acc_we       = we_q;
    acc_addr     = addr_q;
    acc_wdata    = wdata_q;
    acc_strobe   = strobe_q;
    acc_fire     = 1'b0;
    if (state_q == S_IDLE) begin
      acc_we     = req_we_i;
      acc_addr   = req_addr_i;
      acc_wdata  = req_wdata_i;
      acc_strobe = req_strobe_i;
      acc_fire   = req_valid_i && (WAIT_STATES == 0);
    end else if (state_q == S_WAIT) begin
      acc_fire   = (cnt_q == LAST_CNT);
    end
    acc_idx      = acc_addr[AW+1:2];
    acc_in_range = (acc_addr[XLEN-1:AW+2] == '0);
    rsp_rdata_d  = (acc_in_range && !acc_we) ? mem_q[acc_idx] : '0;
    rsp_err_d    = !acc_in_range;
  end

  // Lanes are chosen by strobe alone; the two low address bits carry no meaning.
  assign unused_addr_lsb = ^acc_addr[1:0];

  // Array write port. Reset on the access edge drops the store.
  always_ff @(posedge clk_i) begin
    if (!rst_i && acc_fire && acc_we && acc_in_range) begin
      for (int unsigned i = 0; i < NLANES; i++) begin
        if (acc_strobe[i]) begin
          mem_q[acc_idx][8*i +: 8] <= acc_wdata[8*i +: 8];
        end
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      req_ready_q <= 1'b1;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (req_valid_i) begin
            we_q        <= req_we_i;
            addr_q      <= req_addr_i;
            wdata_q     <= req_wdata_i;
            strobe_q    <= req_strobe_i;
            cnt_q       <= '0;
            req_ready_q <= 1'b0;
            if (WAIT_STATES == 0) begin
              state_q     <= S_RESP;
              rsp_valid_q <= 1'b1;
              rsp_rdata_q <= rsp_rdata_d;
              rsp_err_q   <= rsp_err_d;
            end else begin
              state_q     <= S_WAIT;
            end
          end
        end
        S_WAIT: begin
          if (cnt_q == LAST_CNT) begin
            state_q     <= S_RESP;
            rsp_valid_q <= 1'b1;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_err_q   <= rsp_err_d;
          end else begin
            cnt_q <= cnt_q + 3'd1;
          end
        end
        S_RESP: begin
          if (rsp_ready_i) begin
            state_q     <= S_IDLE;
            req_ready_q <= 1'b1;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign req_ready_o = req_ready_q;
  assign rsp_valid_o = rsp_valid_q;
  assign rsp_rdata_o = rsp_rdata_q;
  assign rsp_err_o   = rsp_err_q;

endmodule

// File: tb/tb_data_mem_responder.sv
`timescale 1ns/1ps
module tb_data_mem_responder;

  localparam int NI    = 4;
  localparam int DEPTH = 1024;

  function automatic int unsigned ws_of(input int g);
    case (g)
      0:       return 0;
      1:       return 1;
      2:       return 3;
      default: return 7;
    endcase
  endfunction

  logic            clk = 1'b0;
  logic [NI-1:0]   rst;
  logic [NI-1:0]   req_valid;
  logic [NI-1:0]   req_ready;
  logic [NI-1:0]   req_we;
  logic [NI-1:0]   rsp_valid;
  logic [NI-1:0]   rsp_ready;
  logic [NI-1:0]   rsp_err;
  logic [31:0]     req_addr  [NI];
  logic [31:0]     req_wdata [NI];
  logic [3:0]      req_strobe[NI];
  logic [31:0]     rsp_rdata [NI];

  int n_cmp = 0;
  int n_err = 0;

  // Byte-addressed reference image per instance.
  bit [7:0] mb [NI][DEPTH*4];

  always #5 clk = ~clk;

  for (genvar g = 0; g < NI; g++) begin : g_dut
    data_mem_responder #(
      .XLEN        (32),
      .DEPTH_WORDS (DEPTH),
      .WAIT_STATES (ws_of(g))
    ) u_dut (
      .clk_i        (clk),
      .rst_i        (rst[g]),
      .req_valid_i  (req_valid[g]),
      .req_ready_o  (req_ready[g]),
      .req_we_i     (req_we[g]),
      .req_addr_i   (req_addr[g]),
      .req_wdata_i  (req_wdata[g]),
      .req_strobe_i (req_strobe[g]),
      .rsp_valid_o  (rsp_valid[g]),
      .rsp_ready_i  (rsp_ready[g]),
      .rsp_rdata_o  (rsp_rdata[g]),
      .rsp_err_o    (rsp_err[g])
    );
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  function automatic bit in_rng(input logic [31:0] a);
    return a < 32'(DEPTH * 4);
  endfunction

  function automatic logic [31:0] mdl_word(input int k, input logic [31:0] a);
    int b;
    b = int'(a) - (int'(a) % 4);
    return {mb[k][b+3], mb[k][b+2], mb[k][b+1], mb[k][b]};
  endfunction

  function automatic logic [31:0] pick_addr();
    int r;
    r = $urandom_range(0, 9);
    if (r == 0) return 32'h1000 | 32'($urandom_range(0, 32'hFFFF));
    if (r == 1) return 32'h8000_0000 | 32'($urandom_range(0, 3));
    if (r == 2) return 32'hFFC | 32'($urandom_range(0, 3));
    return 32'($urandom_range(0, 15) * 4 + $urandom_range(0, 3));
  endfunction

  // One full transaction; entered and left one time unit after a rising edge.
  task automatic txn(input int k, input bit we, input logic [31:0] a,
                     input logic [31:0] wd, input logic [3:0] sb, input int stall);
    logic [31:0] exp_d;
    logic        exp_e;
    int          cyc;
    bit          ok;
    string       t;
    ok    = in_rng(a);
    exp_e = !ok;
    exp_d = (ok && !we) ? mdl_word(k, a) : 32'h0;
    t = $sformatf("i%0d %s@%08h", k, we ? "st" : "ld", a);
    chk({t, " ready_idle"}, 32'(req_ready[k]), 32'd1);
    req_valid[k] = 1'b1; req_we[k] = we; req_addr[k] = a;
    req_wdata[k] = wd;   req_strobe[k] = sb;
    @(posedge clk); #1;
    req_valid[k] = 1'b0;
    cyc = 1;
    while (!rsp_valid[k] && cyc < 20) begin
      @(posedge clk); #1;
      cyc++;
    end
    chk({t, " latency"}, 32'(cyc), 32'(ws_of(k) + 1));
    for (int s = 0; s < stall; s++) begin
      chk({t, " stall_valid"}, 32'(rsp_valid[k]), 32'd1);
      chk({t, " stall_rdata"}, rsp_rdata[k], exp_d);
      chk({t, " stall_ready"}, 32'(req_ready[k]), 32'd0);
      // Competing request during the response window must be ignored.
      req_valid[k] = 1'b1; req_we[k] = 1'b1; req_addr[k] = a & 32'hFFC;
      req_wdata[k] = $urandom; req_strobe[k] = 4'hF;
      @(posedge clk); #1;
    end
    req_valid[k] = 1'b0;
    chk({t, " valid"}, 32'(rsp_valid[k]), 32'd1);
    chk({t, " rdata"}, rsp_rdata[k], exp_d);
    chk({t, " err"},   32'(rsp_err[k]), 32'(exp_e));
    rsp_ready[k] = 1'b1;
    @(posedge clk); #1;
    rsp_ready[k] = 1'b0;
    chk({t, " valid_drop"}, 32'(rsp_valid[k]), 32'd0);
    chk({t, " ready_back"}, 32'(req_ready[k]), 32'd1);
    if (we && ok) begin
      for (int i = 0; i < 4; i++) begin
        if (sb[i]) mb[k][(int'(a) - (int'(a) % 4)) + i] = wd[8*i +: 8];
      end
    end
  endtask

  initial begin
    logic [31:0] old;
    int          cyc;

    rst = '1; req_valid = '0; req_we = '0; rsp_ready = '0;
    for (int k = 0; k < NI; k++) begin
      req_addr[k] = '0; req_wdata[k] = '0; req_strobe[k] = '0;
    end
    repeat (2) @(posedge clk);
    #1 rst = '0;
    @(posedge clk); #1;
    for (int k = 0; k < NI; k++) begin
      chk($sformatf("i%0d rst_ready", k), 32'(req_ready[k]), 32'd1);
      chk($sformatf("i%0d rst_valid", k), 32'(rsp_valid[k]), 32'd0);
      chk($sformatf("i%0d rst_rdata", k), rsp_rdata[k], 32'd0);
      chk($sformatf("i%0d rst_err", k),   32'(rsp_err[k]), 32'd0);
    end

    // Known contents for every word the bench will ever read.
    for (int k = 0; k < NI; k++) begin
      for (int w = 0; w < 16; w++) txn(k, 1'b1, 32'(w * 4), $urandom, 4'hF, 0);
      txn(k, 1'b1, 32'hFFC, $urandom, 4'hF, 0);
    end

    // Directed cases on the single-wait-state instance.
    txn(1, 1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 0);
    txn(1, 1'b0, 32'h10, 32'h0, 4'h0, 0);
    txn(1, 1'b1, 32'h20, 32'h11223344, 4'hF, 0);
    txn(1, 1'b1, 32'h20, 32'h000000AA, 4'b0001, 0);
    txn(1, 1'b0, 32'h20, 32'h0, 4'h0, 0);
    txn(1, 1'b1, 32'h20, 32'h0000BBCC, 4'b0011, 0);
    txn(1, 1'b0, 32'h20, 32'h0, 4'h0, 0);
    txn(1, 1'b0, 32'h10, 32'h0, 4'h0, 5);
    txn(1, 1'b0, 32'h10, 32'h0, 4'h0, 0);
    txn(1, 1'b1, 32'h1000, 32'hCAFEF00D, 4'hF, 0);
    txn(1, 1'b0, 32'h0, 32'h0, 4'h0, 0);
    txn(1, 1'b0, 32'h1000, 32'h0, 4'h0, 0);

    // Zero strobe on the fastest and slowest instances.
    txn(0, 1'b1, 32'h8, 32'h5A5A5A5A, 4'h0, 0);
    txn(0, 1'b0, 32'h8, 32'h0, 4'h0, 0);
    txn(3, 1'b1, 32'h8, 32'hA5A5A5A5, 4'h0, 0);
    txn(3, 1'b0, 32'h8, 32'h0, 4'h0, 0);

    // Response ready while idle does nothing.
    rsp_ready[0] = 1'b1;
    repeat (2) begin
      @(posedge clk); #1;
      chk("i0 idle_rsp_ready_valid", 32'(rsp_valid[0]), 32'd0);
      chk("i0 idle_rsp_ready_ready", 32'(req_ready[0]), 32'd1);
    end
    rsp_ready[0] = 1'b0;

    // Reset one cycle after a store is accepted.
    old = mdl_word(2, 32'h30);
    req_valid[2] = 1'b1; req_we[2] = 1'b1; req_addr[2] = 32'h30;
    req_wdata[2] = ~old; req_strobe[2] = 4'hF;
    @(posedge clk); #1;
    req_valid[2] = 1'b0;
    chk("i2 midop_accepted", 32'(req_ready[2]), 32'd0);
    rst[2] = 1'b1;
    @(posedge clk); #1;
    rst[2] = 1'b0;
    chk("i2 midop_ready", 32'(req_ready[2]), 32'd1);
    chk("i2 midop_valid", 32'(rsp_valid[2]), 32'd0);
    cyc = 0;
    repeat (10) begin
      @(posedge clk); #1;
      if (rsp_valid[2]) cyc++;
    end
    chk("i2 midop_no_rsp", 32'(cyc), 32'd0);
    txn(2, 1'b0, 32'h30, 32'h0, 4'h0, 0);

    // Reset while a response is pending discards it.
    req_valid[3] = 1'b1; req_we[3] = 1'b0; req_addr[3] = 32'h20;
    @(posedge clk); #1;
    req_valid[3] = 1'b0;
    cyc = 1;
    while (!rsp_valid[3] && cyc < 20) begin
      @(posedge clk); #1;
      cyc++;
    end
    chk("i3 resp_reset_latency", 32'(cyc), 32'd8);
    rst[3] = 1'b1;
    @(posedge clk); #1;
    rst[3] = 1'b0;
    chk("i3 resp_reset_valid", 32'(rsp_valid[3]), 32'd0);
    chk("i3 resp_reset_ready", 32'(req_ready[3]), 32'd1);
    chk("i3 resp_reset_rdata", rsp_rdata[3], 32'd0);
    txn(3, 1'b0, 32'h20, 32'h0, 4'h0, 0);

    // Randomised traffic across all wait-state configurations.
    for (int n = 0; n < 200; n++) begin
      txn($urandom_range(0, NI - 1), 1'($urandom_range(0, 1)), pick_addr(),
          $urandom, 4'($urandom_range(0, 15)), $urandom_range(0, 3));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
